// File: rtl/aes_pkg.sv
// Shared AES types, the GF(2^8) reduction polynomial and the xtime helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mix_fsm_t;

    // Multiply by 2 in GF(2^8): shift left, reduce when the top bit falls out.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column_word.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row 0 in the MSB).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller registers the result.
module aes_mix_column_word
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  word_t col_i,
    output word_t col_o
);

    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];

    // Split the column into bytes and build the 2x/4x/8x multiples by chained xtime.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = col_i[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
    end

    // Combine the multiples: forward uses {2,3,1,1}, inverse uses {14,11,13,9}.
    always_comb begin
        col_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (INVERSE) begin
                col_o[31-8*i -: 8] = (x8[i]       ^ x4[i]       ^ x2[i])            // 14
                                   ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])       // 11
                                   ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])       // 13
                                   ^ (x8[(i+3)%4] ^ a[(i+3)%4]);                    // 9
            end else begin
                col_o[31-8*i -: 8] = x2[i]
                                   ^ (x2[(i+1)%4] ^ a[(i+1)%4])
                                   ^ a[(i+2)%4]
                                   ^ a[(i+3)%4];
            end
        end
    end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential MixColumns: accepts one 128-bit state, mixes one column per clock in place.
// Latency: 4 cycles from accept edge to out_valid; next accept no sooner than 6 cycles later.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    mix_fsm_t   fsm_q, fsm_d;
    logic [1:0] col_q, col_d;
    state_t     state_q, state_d;

    word_t      col_sel;
    word_t      col_mix;

    // Pick the column currently being mixed.
    always_comb begin
        unique case (col_q)
            2'd0:    col_sel = state_q[127:96];
            2'd1:    col_sel = state_q[95:64];
            2'd2:    col_sel = state_q[63:32];
            default: col_sel = state_q[31:0];
        endcase
    end

    aes_mix_column_word #(
        .INVERSE (INVERSE)
    ) u_mix (
        .col_i (col_sel),
        .col_o (col_mix)
    );

    // Next-state, handshake outputs and in-place column writeback.
    always_comb begin
        fsm_d     = fsm_q;
        col_d     = col_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data;
                    col_d   = 2'd0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                unique case (col_q)
                    2'd0:    state_d[127:96] = col_mix;
                    2'd1:    state_d[95:64]  = col_mix;
                    2'd2:    state_d[63:32]  = col_mix;
                    default: state_d[31:0]   = col_mix;
                endcase
                // Natural 2-bit wrap returns col to 0 after the last column.
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                col_d = 2'd0;
            end
        endcase
    end

    // State, column counter and data registers; reset drops any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            col_q   <= 2'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            col_q   <= col_d;
            state_q <= state_d;
        end
    end

    assign out_data = state_q;

endmodule
